beat_stepper: RTL and testbench

BEAT_STEPPER -- requirements
Module: beat_stepper

---
 rtl/beat_stepper.sv | 110 +++++++++++
 tb/tb_beat_stepper.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/beat_stepper.sv
// Step sequencer clock: divides clk by a latched tempo period into step ticks,
// walks a step index around a bar, and supports pause, resume and restart.
module beat_stepper #(
    parameter int STEPS  = 16,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [27:0]       period,
    input  logic              run,
    input  logic              restart,
    output logic              tick,
    output logic [STEP_W-1:0] step,
    output logic              bar_pulse,
    output logic              running
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [27:0]       cnt_q, cnt_d;
    logic [27:0]       period_q, period_d;
    logic [27:0]       period_clamped;
    logic [STEP_W-1:0] step_q, step_d;
    logic              tick_q, tick_d;
    logic              bar_q, bar_d;
    logic              running_q, running_d;
    logic              last_cnt;
    logic              last_step;

    // A period below 2 would make ticks collide, so it is floored at latch time.
    assign period_clamped = (period < 28'd2) ? 28'd2 : period;
    assign last_cnt       = (cnt_q == period_q - 28'd1);
    assign last_step      = (step_q == STEP_W'(STEPS - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        step_d   = step_q;
        tick_d   = 1'b0;
        bar_d    = 1'b0;
        if (restart) begin
            state_d = IDLE;
            cnt_d   = '0;
            step_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (run) begin
                        state_d  = RUN;
                        period_d = period_clamped;
                        cnt_d    = '0;
                        step_d   = '0;
                        tick_d   = 1'b1;
                    end
                end
                // Resuming from PAUSE counts on the same edge, continuing the held cnt.
                RUN, PAUSE: begin
                    if (!run) begin
                        state_d = PAUSE;
                    end else begin
                        state_d = RUN;
                        if (last_cnt) begin
                            cnt_d    = '0;
                            tick_d   = 1'b1;
                            bar_d    = last_step;
                            step_d   = last_step ? '0 : step_q + STEP_W'(1);
                            period_d = period_clamped;
                        end else begin
                            cnt_d = cnt_q + 28'd1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        running_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            period_q  <= 28'd2;
            step_q    <= '0;
            tick_q    <= 1'b0;
            bar_q     <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            step_q    <= step_d;
            tick_q    <= tick_d;
            bar_q     <= bar_d;
            running_q <= running_d;
        end
    end

    assign tick      = tick_q;
    assign step      = step_q;
    assign bar_pulse = bar_q;
    assign running   = running_q;

endmodule

// File: tb/tb_beat_stepper.sv
// Randomised and directed bench for beat_stepper, checking a 16-step and a
// 4-step instance against a tick-count reference model.
module tb_beat_stepper;

    logic        clk;
    logic        resetn;
    logic [27:0] period;
    logic        run;
    logic        restart;

    logic        tick16, bar16, run16;
    logic [3:0]  step16;
    logic        tick4, bar4, run4;
    logic [1:0]  step4;

    int vectors;
    int miscompares;

    // Model: m_n ticks since the start tick, m_left cycles until the next one.
    bit          m_started;
    int          m_left;
    int          m_n;
    bit          e_tick;
    bit          e_run;

    beat_stepper u16 (
        .clk(clk), .resetn(resetn), .period(period), .run(run),
        .restart(restart), .tick(tick16), .step(step16),
        .bar_pulse(bar16), .running(run16)
    );

    beat_stepper #(.STEPS(4), .STEP_W(2)) u4 (
        .clk(clk), .resetn(resetn), .period(period), .run(run),
        .restart(restart), .tick(tick4), .step(step4),
        .bar_pulse(bar4), .running(run4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int clampp(input logic [27:0] p);
        return (p < 2) ? 2 : int'(p);
    endfunction

    function automatic logic [11:0] obs();
        return {tick16, bar16, run16, step16, tick4, bar4, run4, step4};
    endfunction

    function automatic logic [11:0] expv();
        logic b16, b4;
        b16 = e_tick && m_n > 0 && (m_n % 16) == 0;
        b4  = e_tick && m_n > 0 && (m_n % 4) == 0;
        return {e_tick, b16, e_run, 4'(m_n % 16),
                e_tick, b4, e_run, 2'(m_n % 4)};
    endfunction

    task automatic model_reset();
        m_started = 0;
        m_left    = 0;
        m_n       = 0;
        e_tick    = 0;
        e_run     = 0;
    endtask

    task automatic cycle(input bit rs, input bit rn, input logic [27:0] p);
        restart = rs;
        run     = rn;
        period  = p;
        @(posedge clk);
        e_tick = 0;
        if (rs) begin
            m_started = 0;
            m_n       = 0;
            e_run     = 0;
        end else if (!m_started) begin
            if (rn) begin
                m_started = 1;
                m_n       = 0;
                m_left    = clampp(p);
                e_tick    = 1;
            end
            e_run = rn;
        end else begin
            if (rn) begin
                m_left--;
                if (m_left == 0) begin
                    m_n++;
                    m_left = clampp(p);
                    e_tick = 1;
                end
            end
            e_run = rn;
        end
        #1;
    endtask

    task automatic test_reset();
        resetn  = 1'b0;
        run     = 1'b0;
        restart = 1'b0;
        period  = 28'd4;
        model_reset();
        #12;
        vectors++;
        if (obs() !== 12'h000) begin
            $display("FAIL reset_hold: got %h want %h", obs(), 12'h000);
            miscompares++;
        end
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 4);
            vectors++;
            if (obs() !== expv()) begin
                $display("FAIL reset_idle c%0d: got %h want %h", i, obs(), expv());
                miscompares++;
            end
        end
    endtask

    task automatic test_basic();
        logic [6:0] want, got;
        cycle(1, 0, 4);
        for (int i = 0; i < 40; i++) begin
            cycle(0, 1, 4);
            want = {(i % 4) == 0, 1'b0, 1'b1, 4'(i / 4)};
            got  = {tick16, bar16, run16, step16};
            vectors++;
            if (got !== want) begin
                $display("FAIL basic_p4 c%0d: got %h want %h", i, got, want);
                miscompares++;
            end
        end
    endtask

    task automatic test_bar();
        logic [3:0] want, got;
        int bars;
        bars = 0;
        cycle(1, 0, 3);
        for (int i = 0; i < 36; i++) begin
            cycle(0, 1, 3);
            if (bar4) bars++;
            want = {(i % 3) == 0, (i == 12 || i == 24), 2'((i / 3) % 4)};
            got  = {tick4, bar4, step4};
            vectors++;
            if (got !== want) begin
                $display("FAIL bar_s4 c%0d: got %h want %h", i, got, want);
                miscompares++;
            end
        end
        vectors++;
        if (bars !== 2) begin
            $display("FAIL bar_count: got %0d want %0d", bars, 2);
            miscompares++;
        end
    endtask

    task automatic test_period_change();
        logic [4:0] want, got;
        bit t;
        int s;
        cycle(1, 0, 8);
        for (int i = 0; i < 20; i++) begin
            cycle(0, 1, (i < 4) ? 28'd8 : 28'd2);
            t = (i == 0) || (i >= 8 && ((i - 8) % 2) == 0);
            s = (i < 8) ? 0 : 1 + (i - 8) / 2;
            want = {t, 4'(s)};
            got  = {tick16, step16};
            vectors++;
            if (got !== want) begin
                $display("FAIL period_change c%0d: got %h want %h", i, got, want);
                miscompares++;
            end
        end
    endtask

    task automatic test_clamp();
        logic [5:0] want, got;
        cycle(1, 0, 0);
        for (int i = 0; i < 20; i++) begin
            cycle(0, 1, (i < 10) ? 28'd0 : 28'd1);
            want = {(i % 2) == 0, 1'b1, 4'(i / 2)};
            got  = {tick16, run16, step16};
            vectors++;
            if (got !== want) begin
                $display("FAIL clamp c%0d: got %h want %h", i, got, want);
                miscompares++;
            end
        end
    endtask

    task automatic test_pause();
        logic [5:0] want, got;
        cycle(1, 0, 5);
        for (int i = 0; i < 3; i++) cycle(0, 1, 5);
        for (int i = 0; i < 7; i++) begin
            cycle(0, 0, 5);
            want = {1'b0, 1'b0, 4'd0};
            got  = {tick16, run16, step16};
            vectors++;
            if (got !== want) begin
                $display("FAIL pause_hold c%0d: got %h want %h", i, got, want);
                miscompares++;
            end
        end
        for (int j = 1; j <= 6; j++) begin
            cycle(0, 1, 5);
            want = {j == 3, 1'b1, (j >= 3) ? 4'd1 : 4'd0};
            got  = {tick16, run16, step16};
            vectors++;
            if (got !== want || obs() !== expv()) begin
                $display("FAIL pause_resume c%0d: got %h/%h want %h/%h",
                         j, got, obs(), want, expv());
                miscompares++;
            end
        end
    endtask

    task automatic test_restart();
        cycle(1, 0, 3);
        for (int i = 0; i < 16; i++) cycle(0, 1, 3);
        vectors++;
        if (step16 !== 4'd5) begin
            $display("FAIL restart_pre: got %0d want %0d", step16, 5);
            miscompares++;
        end
        cycle(1, 1, 3);
        vectors++;
        if (obs() !== 12'h000) begin
            $display("FAIL restart_clear: got %h want %h", obs(), 12'h000);
            miscompares++;
        end
        for (int k = 0; k < 8; k++) begin
            cycle(0, 1, 3);
            vectors++;
            if (obs() !== expv() || tick16 !== ((k % 3) == 0)) begin
                $display("FAIL restart_run c%0d: got %h want %h", k, obs(), expv());
                miscompares++;
            end
        end
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        vectors++;
        if (obs() !== 12'h000) begin
            $display("FAIL async_reset: got %h want %h", obs(), 12'h000);
            miscompares++;
        end
        @(posedge clk);
        #4;
        resetn = 1'b1;
        for (int k = 0; k < 7; k++) begin
            cycle(0, 1, 3);
            vectors++;
            if (obs() !== expv()) begin
                $display("FAIL after_reset c%0d: got %h want %h", k, obs(), expv());
                miscompares++;
            end
        end
    endtask

    task automatic test_random();
        bit rs, rn;
        logic [27:0] p;
        for (int i = 0; i < 600; i++) begin
            rs = ($urandom_range(0, 39) == 0);
            rn = ($urandom_range(0, 7) != 0);
            p  = 28'($urandom_range(0, 6));
            cycle(rs, rn, p);
            vectors++;
            if (obs() !== expv()) begin
                $display("FAIL random c%0d: got %h want %h", i, obs(), expv());
                miscompares++;
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_basic();
        test_bar();
        test_period_change();
        test_clamp();
        test_pause();
        test_restart();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
